// File: rtl/response_checker.sv
// Result-stream checker: compares each accepted word against a preloaded table of expected words.
// Optional MISR signature over accepted words is enabled by defining CHECK_SIGNATURE_EN.
module response_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [WIDTH-1:0]         exp_data,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [CNT_W-1:0]         err_count,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic [WIDTH-1:0]         signature
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   table_q [DEPTH];
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   err_count_q;
    logic [CNT_W-1:0]   err_count_d;
    logic [IDX_W-1:0]   first_err_idx_q;
    logic               err_seen_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    logic               accept;
    logic               mismatch;
    logic               last_word;
    logic               table_wr;

    // Handshake: in_ready is high exactly while in RUN; a word transfers on a
    // rising edge where in_valid && in_ready. Outside RUN nothing is consumed.
    always_comb begin
        accept      = 1'b0;
        mismatch    = 1'b0;
        last_word   = 1'b0;
        err_count_d = err_count_q;
        table_wr    = 1'b0;
        accept      = (state_q == RUN) && in_valid;
        mismatch    = accept && (in_data != table_q[idx_q]);
        last_word   = (idx_q == IDX_W'(DEPTH - 1));
        if (err_count_q != {CNT_W{1'b1}}) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        table_wr    = exp_we && (state_q != RUN)
                      && ({1'b0, exp_addr} < (IDX_W + 1)'(DEPTH));
    end

    // The table is deliberately left out of reset so a harness can preload it once.
    always_ff @(posedge clk) begin
        if (table_wr) begin
            table_q[exp_addr] <= exp_data;
        end
    end

`ifdef CHECK_SIGNATURE_EN
    localparam logic [WIDTH-1:0] SIG_TAPS = WIDTH'(32'h8020_0003);
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = {sig_q[WIDTH-2:0], ^(sig_q & SIG_TAPS)} ^ in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else if ((state_q != RUN) && start) begin
            sig_q <= '0;
        end else if (accept) begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            err_seen_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q         <= RUN;
                        idx_q           <= '0;
                        err_count_q     <= '0;
                        first_err_idx_q <= '0;
                        err_seen_q      <= 1'b0;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (mismatch) begin
                            err_count_q <= err_count_d;
                            if (!err_seen_q) begin
                                first_err_idx_q <= idx_q;
                                err_seen_q      <= 1'b1;
                            end
                        end
                        idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
                        if (last_word) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // pass when neither this word nor any earlier word of the run miscompared
                            pass_q  <= !(mismatch || err_seen_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = (state_q == RUN);
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker; CNT_W is reduced to 3 so err_count saturation is reachable.
module tb_response_checker;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             exp_we;
    logic [2:0]       exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [2:0]       first_err_idx;
    logic [WIDTH-1:0] signature;

    response_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .signature(signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] words [8];
    logic [WIDTH-1:0] sig_m;
    logic [WIDTH-1:0] sig_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] sig_step(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], ^(s & 32'h8020_0003)} ^ d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        sig_m = '0;
    endtask

    // Called only while the checker is in RUN, so every call is one accepted word.
    task automatic feed(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
`ifdef CHECK_SIGNATURE_EN
        sig_m = sig_step(sig_m, d);
`endif
    endtask

    initial begin
        int acc;
        words[0] = 32'h0000_0000; words[1] = 32'h0000_0001;
        words[2] = 32'h0000_1000; words[3] = 32'h1000_0000;
        words[4] = 32'h0000_0001; words[5] = 32'h0000_1001;
        words[6] = 32'h1000_1000; words[7] = 32'h1000_0001;
        rst = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        start = 1'b0; in_valid = 1'b0; in_data = '0; sig_m = '0; sig_s2 = '0;

        // Reset
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_first_err", 32'(first_err_idx), 0);
        check("rst_signature", signature, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            exp_we = 1'b1; exp_addr = 3'(i); exp_data = words[i];
            tick();
        end
        exp_we = 1'b0;
        // in_valid while idle must not consume anything
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        tick(); tick();
        in_valid = 1'b0;
        check("idle_busy", 32'(busy), 0);

        // All match
        do_start();
        check("s2_busy", 32'(busy), 1);
        check("s2_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 7; i++) feed(words[i]);
        check("s2_done_early", 32'(done), 0);
        feed(words[7]);
        check("s2_done", 32'(done), 1);
        check("s2_pass", 32'(pass), 1);
        check("s2_err_count", 32'(err_count), 0);
        check("s2_busy_off", 32'(busy), 0);
        check("s2_in_ready_off", 32'(in_ready), 0);
`ifdef CHECK_SIGNATURE_EN
        check("s2_signature", signature, sig_m);
`else
        check("s2_signature", signature, 0);
`endif
        sig_s2 = sig_m;
        in_valid = 1'b1; in_data = 32'h1234_5678;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("done_hold_done", 32'(done), 1);
        check("done_hold_err", 32'(err_count), 0);

        // Two mismatches
        do_start();
        check("s3_done_cleared", 32'(done), 0);
        check("s3_pass_cleared", 32'(pass), 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) feed(32'h1000_0001);
            else if (i == 6) feed(32'h0000_0000);
            else feed(words[i]);
        end
        check("s3_done", 32'(done), 1);
        check("s3_err_count", 32'(err_count), 2);
        check("s3_first_err", 32'(first_err_idx), 3);
        check("s3_pass", 32'(pass), 0);

        // Gapped valid: pattern 1,0,0 repeating
        do_start();
        acc = 0;
        for (int c = 0; c < 100 && acc < 7; c++) begin
            if (c % 3 == 0) begin
                feed(words[acc]);
                acc++;
            end else begin
                in_valid = 1'b0;
                tick();
            end
        end
        check("s4_accepts", 32'(acc), 7);
        tick(); tick();
        check("s4_done_early", 32'(done), 0);
        feed(words[7]);
        check("s4_done", 32'(done), 1);
        check("s4_pass", 32'(pass), 1);
        check("s4_err_count", 32'(err_count), 0);

        // Mid-run reset after 4 accepts, one of them wrong
        do_start();
        feed(words[0]); feed(32'hDEAD_0000); feed(words[2]); feed(words[3]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sig_m = '0;
        check("s5_busy", 32'(busy), 0);
        check("s5_in_ready", 32'(in_ready), 0);
        check("s5_err_count", 32'(err_count), 0);
        check("s5_first_err", 32'(first_err_idx), 0);
        check("s5_signature", signature, 0);
        do_start();
        for (int i = 0; i < 7; i++) feed(words[i]);
        feed(32'h0000_0007);
        check("s5_done", 32'(done), 1);
        check("s5_err_count2", 32'(err_count), 1);
        check("s5_first_err2", 32'(first_err_idx), 7);
        check("s5_pass", 32'(pass), 0);

        // start and exp_we during RUN are ignored
        do_start();
        exp_we = 1'b1; exp_addr = 3'd2; exp_data = 32'hDEAD_BEEF;
        feed(words[0]);
        exp_we = 1'b0;
        for (int i = 1; i < 4; i++) feed(words[i]);
        start = 1'b1;
        feed(words[4]);
        start = 1'b0;
        for (int i = 5; i < 8; i++) feed(words[i]);
        check("s6_done", 32'(done), 1);
        check("s6_pass", 32'(pass), 1);
        check("s6_err_count", 32'(err_count), 0);
`ifdef CHECK_SIGNATURE_EN
        check("s6_sig_repeat", signature, sig_s2);
`else
        check("s6_signature", signature, 0);
`endif

        // exp_we together with start from DONE: first compare sees new entry
        exp_we = 1'b1; exp_addr = 3'd0; exp_data = 32'h0000_0055;
        do_start();
        exp_we = 1'b0;
        feed(32'h0000_0055);
        for (int i = 1; i < 8; i++) feed(words[i]);
        check("wr_start_pass", 32'(pass), 1);
        check("wr_start_err", 32'(err_count), 0);
`ifdef CHECK_SIGNATURE_EN
        check("wr_start_sig", signature, sig_m);
`endif

        // Every word wrong: err_count saturates at 7
        do_start();
        feed(32'h0000_0000);
        for (int i = 1; i < 8; i++) feed(words[i] ^ 32'h8000_0000);
        check("sat_err_count", 32'(err_count), 7);
        check("sat_first_err", 32'(first_err_idx), 0);
        check("sat_pass", 32'(pass), 0);

        // Restore entry 0 while in DONE, then a clean run
        exp_we = 1'b1; exp_addr = 3'd0; exp_data = words[0];
        tick();
        exp_we = 1'b0;
        check("done_write_hold", 32'(done), 1);
        do_start();
        for (int i = 0; i < 8; i++) feed(words[i]);
        check("restore_pass", 32'(pass), 1);
        check("restore_err", 32'(err_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
